encoder_rpm: RTL

- Upstream measurement stage for the traction PID loop.
- Decodes one quadrature wheel encoder (A/B) and produces the signed RPM word consumed by the PID block's RPM_Medidas input, once per fixed gate window.
- Also keeps a free-running signed position count and an illegal-transition counter for diagnostics (exported to the Avalon register map by the wrapper).

---
 rtl/encoder_rpm.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/encoder_rpm.sv
// Quadrature encoder front end: synchronizer, glitch filter, decoder, position and
// error counters, and a gated-window RPM measurement with a two-stage scale pipeline.
module encoder_rpm #(
  parameter int unsigned GATE_CYCLES = 5000000,
  parameter int unsigned FILTER_LEN  = 4,
  parameter int unsigned RPM_NUM     = 19661,
  parameter int unsigned RPM_SHIFT   = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enc_a,
  input  logic               enc_b,
  input  logic               invert,
  input  logic               clear_err,
  output logic signed [15:0] RPM_Medidas,
  output logic               rpm_valid,
  output logic signed [31:0] pos_count,
  output logic [7:0]         err_count
);

  localparam int unsigned GW = 26;
  localparam logic [GW-1:0] GATE_LAST  = GW'(GATE_CYCLES - 1);
  localparam logic [3:0]    FILT_LAST  = 4'(FILTER_LEN - 1);
  localparam logic [4:0]    PRIME_LAST = 5'(FILTER_LEN + 2);
  localparam logic signed [23:0] WIN_MAX = 24'sd8388607;
  localparam logic [15:0]   NUM = 16'(RPM_NUM);

  function automatic logic signed [23:0] sat_win(input logic signed [24:0] v);
    if (v > 25'sd8388607) return WIN_MAX;
    if (v < -25'sd8388607) return -WIN_MAX;
    return v[23:0];
  endfunction

  function automatic logic signed [15:0] scale_rpm(input logic [39:0] prod, input logic neg);
    logic [39:0] q;
    logic [15:0] m;
    q = prod >> RPM_SHIFT;
    m = (q > 40'd32767) ? 16'd32767 : q[15:0];
    return neg ? -$signed(m) : $signed(m);
  endfunction

  // Channel vectors are packed {A, B}.
  logic [1:0]      sync1_q, sync2_q;
  logic [1:0]      filt_q, filt_d;
  logic [1:0][3:0] stab_q, stab_d;
  logic [1:0]      prev_q;
  logic [4:0]      prime_q;
  logic            primed_q;
  logic [GW-1:0]   gate_q;
  logic signed [23:0] win_q;
  logic signed [31:0] pos_q;
  logic [7:0]      err_q;
  logic            vld_p1_q;
  logic [39:0]     prod_p1_q;
  logic            neg_p1_q;
  logic            vld_p2_q;
  logic signed [15:0] rpm_p2_q;

  logic [1:0]         idx_prev, idx_cur, idx_dif;
  logic signed [1:0]  step_raw, step;
  logic               illegal;
  logic               terminal;
  logic signed [24:0] win_sum;
  logic signed [23:0] win_snap;
  logic [23:0]        win_mag;
  logic [39:0]        prod_d;

  // A filtered level only follows the synchronized level after FILTER_LEN
  // consecutive disagreeing cycles; any agreement restarts the count.
  always_comb begin
    filt_d = filt_q;
    stab_d = '0;
    for (int ch = 0; ch < 2; ch++) begin
      if (sync2_q[ch] != filt_q[ch]) begin
        if (stab_q[ch] == FILT_LAST) filt_d[ch] = sync2_q[ch];
        else stab_d[ch] = stab_q[ch] + 4'd1;
      end
    end
  end

  // Map {A,B} onto its position in the Gray cycle 00,01,11,10 so the
  // modulo-4 difference gives direction (1/3) or a skipped state (2).
  always_comb begin
    idx_prev = {prev_q[1], prev_q[1] ^ prev_q[0]};
    idx_cur  = {filt_q[1], filt_q[1] ^ filt_q[0]};
    idx_dif  = idx_cur - idx_prev;
    step_raw = 2'sd0;
    illegal  = 1'b0;
    if (primed_q) begin
      case (idx_dif)
        2'd1:    step_raw = 2'sd1;
        2'd3:    step_raw = -2'sd1;
        2'd2:    illegal  = 1'b1;
        default: ;
      endcase
    end
    step = invert ? -step_raw : step_raw;
  end

  assign terminal = (gate_q == GATE_LAST);
  assign win_sum  = {win_q[23], win_q} + {{23{step[1]}}, step};
  assign win_snap = sat_win(win_sum);
  assign win_mag  = win_snap[23] ? $unsigned(-win_snap) : $unsigned(win_snap);
  assign prod_d   = {16'd0, win_mag} * {24'd0, NUM};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      filt_q    <= '0;
      stab_q    <= '0;
      prev_q    <= '0;
      prime_q   <= '0;
      primed_q  <= 1'b0;
      gate_q    <= '0;
      win_q     <= '0;
      pos_q     <= '0;
      err_q     <= '0;
      vld_p1_q  <= 1'b0;
      prod_p1_q <= '0;
      neg_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      rpm_p2_q  <= '0;
    end else begin
      sync1_q <= {enc_a, enc_b};
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      stab_q  <= stab_d;
      prev_q  <= filt_q;
      if (!primed_q) begin
        if (prime_q == PRIME_LAST) primed_q <= 1'b1;
        else prime_q <= prime_q + 5'd1;
      end
      pos_q <= pos_q + {{30{step[1]}}, step};
      if (clear_err) err_q <= '0;
      else if (illegal && err_q != 8'hFF) err_q <= err_q + 8'd1;
      // The terminal cycle's own step closes into the snapshot, so the
      // reloaded window starts empty without losing that step.
      if (terminal) begin
        gate_q <= '0;
        win_q  <= '0;
      end else begin
        gate_q <= gate_q + GW'(1);
        win_q  <= win_snap;
      end
      // p1: magnitude times scale numerator
      vld_p1_q <= terminal;
      if (terminal) begin
        prod_p1_q <= prod_d;
        neg_p1_q  <= win_snap[23];
      end
      // p2: shift, clamp, re-apply sign
      vld_p2_q <= vld_p1_q;
      if (vld_p1_q) rpm_p2_q <= scale_rpm(prod_p1_q, neg_p1_q);
    end
  end

  assign RPM_Medidas = rpm_p2_q;
  assign rpm_valid   = vld_p2_q;
  assign pos_count   = pos_q;
  assign err_count   = err_q;

endmodule
